// File: rtl/bcd_counter_pkg.sv
// Shared widths, segment constants and the BCD-to-7-segment decoder for bcd_counter_disp.
// Segment patterns are active-low, bit order gfedcba.
package bcd_counter_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b011_1111;

    // Entry d holds the pattern for decimal digit d.
    localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
        7'b001_0000,  // 9
        7'b000_0000,  // 8
        7'b111_1000,  // 7
        7'b000_0010,  // 6
        7'b001_0010,  // 5
        7'b001_1001,  // 4
        7'b011_0000,  // 3
        7'b010_0100,  // 2
        7'b111_1001,  // 1
        7'b100_0000   // 0
    };

    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] digit);
        logic [SEG_W-1:0] seg;
        if (digit > BCD_W'(9)) begin
            seg = SEG_DASH;
        end else begin
            seg = SEG_TABLE[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD up/down counter: next-digit logic plus carry/borrow toward the
// next more significant digit. Carry/borrow depend only on the digit and direction.
module bcd_digit_cell
    import bcd_counter_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_step,
    input  logic             i_up,
    output logic [BCD_W-1:0] o_next,
    output logic             o_carry,
    output logic             o_borrow
);

    always_comb begin
        o_carry  = i_up && (i_digit == BCD_W'(9));
        o_borrow = !i_up && (i_digit == '0);
        o_next   = i_digit;
        if (i_step) begin
            if (i_up) begin
                o_next = o_carry ? '0 : i_digit + 1'b1;
            end else begin
                o_next = o_borrow ? BCD_W'(9) : i_digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_disp.sv
// N-digit BCD up/down counter with prescaler, load, clear, wrap pulse and 7-segment outputs.
// Define BCD_COUNTER_LZ_BLANK_EN to blank leading zeros on digits above digit 0.
module bcd_counter_disp
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_up,
    input  logic                    i_load,
    input  logic [BCD_W*DIGITS-1:0] i_load_val,
    output logic [BCD_W*DIGITS-1:0] o_bcd,
    output logic [SEG_W*DIGITS-1:0] o_seg,
    output logic                    o_wrap
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d;
    logic [BCD_W*DIGITS-1:0] bcd_step;
    logic [BCD_W*DIGITS-1:0] load_clamped;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic                    wrap_q, wrap_d;
    logic                    tick;
    logic [DIGITS:0]         step;
    logic [DIGITS-1:0]       carry;
    logic [DIGITS-1:0]       borrow;

    assign tick = i_en && (presc_q == PRESC_MAX);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .i_digit  (bcd_q[BCD_W*k +: BCD_W]),
            .i_step   (step[k]),
            .i_up     (i_up),
            .o_next   (bcd_step[BCD_W*k +: BCD_W]),
            .o_carry  (carry[k]),
            .o_borrow (borrow[k])
        );

        assign load_clamped[BCD_W*k +: BCD_W] =
            (i_load_val[BCD_W*k +: BCD_W] > BCD_W'(9)) ? BCD_W'(9) : i_load_val[BCD_W*k +: BCD_W];
    end

    // Ripple the step upward; a step escaping the top digit is the wrap-around.
    always_comb begin
        step    = '0;
        step[0] = tick;
        for (int k = 0; k < DIGITS; k++) begin
            step[k+1] = step[k] && (carry[k] || borrow[k]);
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (i_clr) begin
            bcd_d   = '0;
            presc_d = '0;
        end else if (i_load) begin
            bcd_d   = load_clamped;
            presc_d = '0;
        end else if (i_en) begin
            bcd_d   = bcd_step;
            wrap_d  = step[DIGITS];
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            bcd_q   <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_bcd  = bcd_q;
    assign o_wrap = wrap_q;

`ifdef BCD_COUNTER_LZ_BLANK_EN
    logic lead_zero;

    // Walk from the most significant digit down; a digit is blank while everything above is zero.
    always_comb begin
        o_seg     = '0;
        lead_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead_zero = lead_zero && (bcd_q[BCD_W*k +: BCD_W] == '0);
            if ((k > 0) && lead_zero) begin
                o_seg[SEG_W*k +: SEG_W] = SEG_BLANK;
            end else begin
                o_seg[SEG_W*k +: SEG_W] = seg_decode(bcd_q[BCD_W*k +: BCD_W]);
            end
        end
    end
`else
    always_comb begin
        o_seg = '0;
        for (int k = 0; k < DIGITS; k++) begin
            o_seg[SEG_W*k +: SEG_W] = seg_decode(bcd_q[BCD_W*k +: BCD_W]);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_counter_disp.sv
// Scoreboard bench for bcd_counter_disp (DIGITS=2, TICK_DIV=4): the driver pushes the
// expected post-edge outputs, the negedge monitor pops and compares them.
module tb_bcd_counter_disp;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        i_rst, i_clr, i_en, i_up, i_load;
    logic [7:0]  i_load_val;
    logic [7:0]  o_bcd;
    logic [13:0] o_seg;
    logic        o_wrap;

    always #5 clk = ~clk;

    bcd_counter_disp #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_bcd      (o_bcd),
        .o_seg      (o_seg),
        .o_wrap     (o_wrap)
    );

    typedef struct packed {
        logic [7:0]  bcd;
        logic        wrap;
        logic [13:0] seg;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   wrap_seen = 0;

    int   m_d0 = 0, m_d1 = 0, m_p = 0;
    logic m_w  = 1'b0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            default: return 7'b011_1111;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t r;
        r.bcd  = {4'(m_d1), 4'(m_d0)};
        r.wrap = m_w;
`ifdef BCD_COUNTER_LZ_BLANK_EN
        r.seg  = {(m_d1 == 0) ? 7'b111_1111 : seg_of(m_d1), seg_of(m_d0)};
`else
        r.seg  = {seg_of(m_d1), seg_of(m_d0)};
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the decimal model, queue the expected outputs.
    task automatic cyc(input logic rst, input logic clr, input logic load,
                       input logic [7:0] val, input logic en, input logic up);
        int v;
        i_rst = rst; i_clr = clr; i_load = load; i_load_val = val; i_en = en; i_up = up;
        if (!rst || clr) begin
            m_d0 = 0; m_d1 = 0; m_p = 0; m_w = 1'b0;
        end else if (load) begin
            m_d0 = (val[3:0] > 4'd9) ? 9 : int'(val[3:0]);
            m_d1 = (val[7:4] > 4'd9) ? 9 : int'(val[7:4]);
            m_p  = 0;
            m_w  = 1'b0;
        end else begin
            m_w = 1'b0;
            if (en) begin
                if (m_p == TICK_DIV - 1) begin
                    m_p = 0;
                    v   = m_d1 * 10 + m_d0;
                    if (up) begin
                        if (v == 99) begin v = 0;  m_w = 1'b1; end else v = v + 1;
                    end else begin
                        if (v == 0)  begin v = 99; m_w = 1'b1; end else v = v - 1;
                    end
                    m_d1 = v / 10;
                    m_d0 = v % 10;
                end else begin
                    m_p = m_p + 1;
                end
            end
        end
        q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("bcd",  32'(o_bcd),  32'(e.bcd));
            check("wrap", 32'(o_wrap), 32'(e.wrap));
            check("seg",  32'(o_seg),  32'(e.seg));
            if (o_wrap === 1'b1) wrap_seen++;
        end
    end

    initial begin
        i_rst = 1'b0; i_clr = 1'b0; i_en = 1'b0; i_up = 1'b1; i_load = 1'b0; i_load_val = 8'h00;

        // reset wins over enable
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // full up-count 00..99 -> 00 -> 01
        repeat (404) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // load 10 then 11 down ticks: 09 .. 00, 99
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
        repeat (44) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // per-digit clamp on load
        cyc(1'b1, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h3B, 1'b0, 1'b1);

        // enable gating holds the prescaler
        cyc(1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // direction toggles between ticks; only the tick-edge value matters
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kb;
            kb = 3'(k);
            cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, kb[0] ^ kb[2]);
        end

        // clear + load + wrapping tick on the same edge
        cyc(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // load on a tick edge restarts the prescaler
        cyc(1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // reset mid-prescale at 57, then first step TICK_DIV cycles after release
        cyc(1'b1, 1'b0, 1'b1, 8'h57, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        check("wrap_count", 32'(wrap_seen), 32'd2);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
